// File: rtl/pipe_ctrl_fsm.sv
// Main pipeline control: decodes the ID instruction into EX/M/WB bundles, drives flushes, and
// sequences HLT -> drain -> done. Load-use stalling exists only with PIPE_HAZARD_STALL_EN.
module pipe_ctrl_fsm #(
  parameter int unsigned INSTR_W      = 32,
  parameter int unsigned OPC_MSB      = 31,
  parameter int unsigned OPC_LSB      = 26,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned RS_LSB       = 21,
  parameter int unsigned RT_LSB       = 16,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic               branch_mispredict,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_rd,
  output logic [3:0]         ex_ctrl,
  output logic [2:0]         m_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic               if_flush,
  output logic               id_flush,
  output logic               ex_flush,
  output logic               stall,
  output logic               illegal_op,
  output logic               done,
  output logic               busy
);

  localparam int unsigned OpcW = OPC_MSB - OPC_LSB + 1;

  localparam logic [OpcW-1:0] OpRtype = OpcW'(6'h00);
  localparam logic [OpcW-1:0] OpJmp   = OpcW'(6'h02);
  localparam logic [OpcW-1:0] OpBeq   = OpcW'(6'h04);
  localparam logic [OpcW-1:0] OpLw    = OpcW'(6'h23);
  localparam logic [OpcW-1:0] OpSw    = OpcW'(6'h2b);
  localparam logic [OpcW-1:0] OpNop   = OpcW'(6'h3e);
  localparam logic [OpcW-1:0] OpHlt   = OpcW'(6'h3f);

  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {StReset, StRun, StDrain, StFinish} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic [OpcW-1:0]  opcode;
  logic             hazard;
  logic [8:0]       bundle;  // {ex, m, wb}
  logic             unused_instr;

  assign opcode       = instr[OPC_MSB:OPC_LSB];
  assign unused_instr = ^instr;

`ifdef PIPE_HAZARD_STALL_EN
  logic [REG_W-1:0] rs, rt;
  logic             uses_rs, uses_rt;

  assign rs = instr[RS_LSB +: REG_W];
  assign rt = instr[RT_LSB +: REG_W];

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      OpRtype, OpSw, OpBeq: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OpLw:    uses_rs = 1'b1;
      default: ;
    endcase
  end

  // r0 is never written, so a load into it cannot create a dependency.
  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((uses_rs && (ex_rd == rs)) || (uses_rt && (ex_rd == rt)));
`else
  logic unused_hazard_in;
  assign unused_hazard_in = ex_mem_read ^ (^ex_rd);
  assign hazard           = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    bundle     = '0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    illegal_op = illegal_q;

    case (state_q)
      StReset: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        busy = 1'b1;
        // Mispredict squashes the wrong-path ID instruction, including a stray HLT.
        if (branch_mispredict) begin
          if_flush = 1'b1;
          id_flush = 1'b1;
        end else if (instr_valid) begin
          if (hazard) begin
            stall = 1'b1;
          end else begin
            case (opcode)
              OpRtype:      bundle = 9'b1100_000_10;
              OpLw:         bundle = 9'b0001_010_11;
              OpSw:         bundle = 9'b0001_001_00;
              OpBeq:        bundle = 9'b0010_100_00;
              OpJmp, OpNop: bundle = '0;
              OpHlt: begin
                state_d = StDrain;
                cnt_d   = DrainLoad;
              end
              default:      illegal_d = 1'b1;
            endcase
          end
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StFinish: begin
        done = 1'b1;
      end
      default: begin
        state_d    = StReset;
        cnt_d      = '0;
        illegal_op = 1'b0;
      end
    endcase
  end

  assign ex_ctrl = bundle[8:5];
  assign m_ctrl  = bundle[4:2];
  assign wb_ctrl = bundle[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: doc/pipe_ctrl_fsm.md
# pipe_ctrl_fsm

Parametrised main control unit for the 5-stage pipeline, successor to the fixed-width decode/flush controller. It decodes the ID-stage instruction into EX/M/WB control bundles and drives the IF/ID/EX flush lines. It adds four behaviours the earlier controller lacked: configurable instruction/field geometry, load-use hazard stalling, a counted pipeline drain after HLT before `done`, and a sticky illegal-opcode flag. It sits between the IF/ID pipeline register and the ID/EX register, alongside the PC and hazard-forwarding logic.

## Interface
- INSTR_W, 32, instruction width
- OPC_MSB, 31, opcode field MSB; opcode field is OPC_MSB..OPC_LSB and matches the shared opcode definitions width
- OPC_LSB, 26, opcode field LSB
- REG_W, 5, register index width
- RS_LSB, 21, LSB of rs field (REG_W bits)
- RT_LSB, 16, LSB of rt field (REG_W bits)
- DRAIN_CYCLES, 4, cycles between leaving RUN on HLT and `done`; legal 1..15
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr  in  INSTR_W  instruction in ID
- instr_valid  in  1  instr is valid; low decodes as NOP
- branch_mispredict  in  1  branch resolved not-as-predicted this cycle
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination register of the EX instruction
- ex_ctrl  out  4  EX control bundle
- m_ctrl  out  3  M control bundle
- wb_ctrl  out  2  WB control bundle
- if_flush, id_flush, ex_flush  out  1 each  stage flushes
- stall  out  1  hold PC and IF/ID, inject bubble into ID/EX
- illegal_op  out  1  sticky: unknown opcode decoded
- done  out  1  program finished
- busy  out  1  high in RUN and DRAIN

## Operation
- States: RESET -> RUN -> DRAIN -> FINISH; FINISH is absorbing until rst. Unreachable encodings -> RESET with all outputs zero.
- RESET: all outputs 0; unconditionally goes to RUN next cycle.
- RUN decode (instr_valid=1), {ex,m,wb}: RTYPE 1100/000/10; LW 0001/010/11; SW 0001/001/00; BEQ 0010/100/00; JMP, NOP, HLT 0000/000/00.
- Unknown opcode: bundles zero; illegal_op set on the next edge and held until rst; execution continues.
- branch_mispredict in RUN: if_flush=1 and id_flush=1, bundles forced zero. ex_flush=0 in all states. Mispredict has priority over stall and over HLT, so a wrong-path HLT is ignored and stays in RUN.
- Load-use hazard, with `PIPE_HAZARD_STALL_EN` only, when ex_mem_read=1, ex_rd!=0, and the conditions below hold:
  - Match: ex_rd equals rs (LW, SW, RTYPE, BEQ) or rt (SW, RTYPE, BEQ).
  - Response: stall=1 and bundles zero; state is unchanged.
  - HLT, JMP and NOP never stall.
- HLT decoded in RUN (valid, no mispredict): next state DRAIN, drain counter loaded DRAIN_CYCLES-1.
- DRAIN: bundles, flushes and stall are 0; counter decrements each cycle; at count 0 goes to FINISH. Instruction inputs are ignored.
- FINISH: done=1, busy=0, all other outputs 0 except illegal_op, which keeps its value.
- Counter width is 4 bits and does not wrap.

## Timing
- Reset values: all outputs 0, state RESET, counter 0, illegal_op 0.
- Async assert of rst mid-RUN or mid-DRAIN clears everything immediately. Deassert: RESET for 1 cycle, then RUN.
- Bundles, flushes and stall are combinational from state and inputs, with zero-cycle latency in RUN.
- State, counter and illegal_op are registered.
- HLT decoded in cycle T: busy stays high and done stays low through cycle T+DRAIN_CYCLES. done rises in cycle T+DRAIN_CYCLES+1.
- Simultaneous hazard and mispredict: the flush wins and stall=0.
- Simultaneous HLT and hazard: no stall, because HLT reads no registers.

## Configuration
- `PIPE_HAZARD_STALL_EN` defined: load-use detection as above.
- `PIPE_HAZARD_STALL_EN` undefined: stall tied 0; ex_mem_read and ex_rd are ignored; the rs/rt fields are unused. Software or forwarding must then cover load-use.

## Test plan
- Reset, then RTYPE, LW, SW, BEQ each valid for 1 cycle -> bundles 1100/000/10, 0001/010/11, 0001/001/00, 0010/100/00; done=0.
- BEQ with branch_mispredict=1 -> if_flush=id_flush=1, bundles 0. A following HLT with mispredict=1 -> state stays RUN, busy=1.
- With macro: ex_mem_read=1, ex_rd=5, RTYPE rt=5 -> stall=1, bundles 0. Same with ex_rd=0 -> stall=0. Without macro -> stall=0.
- HLT at cycle 10 with DRAIN_CYCLES=4 -> done=0 through cycle 14, done=1 from cycle 15 onward, busy=0.
- Opcode outside the defined set -> bundles 0, illegal_op=1 from the next cycle and still 1 after a later HLT reaches FINISH.
- rst asserted during DRAIN -> all outputs 0 immediately; after release, RESET for 1 cycle, then RUN decodes again.
